// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the pipeline front end.
//   PCSRC_*    : encodings of the execute-stage redirect select (PCSrcE)
//   NOP_INSTR  : canonical bubble, addi x0,x0,0
//   fetch_state_e : fetch controller states
package riscv_pkg;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BJAL = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HELD  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Priority: rst > flush_i > stall_i > load_i > bubble.
//   clk, rst        : clock, synchronous active-high reset
//   flush_i         : load a bubble
//   stall_i         : hold current contents
//   load_i          : capture instr_i / pc_i as a valid instruction
//   instr_i, pc_i   : fetched instruction and its address
//   instr_o, pc_o, pc_plus4_o, valid_o : register outputs
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            instr_o    <= NOP_INSTR;
            pc_o       <= 32'd0;
            pc_plus4_o <= 32'd0;
            valid_o    <= 1'b0;
        end else if (stall_i) begin
            instr_o    <= instr_o;
            pc_o       <= pc_o;
            pc_plus4_o <= pc_plus4_o;
            valid_o    <= valid_o;
        end else if (load_i) begin
            instr_o    <= instr_i;
            pc_o       <= pc_i;
            pc_plus4_o <= pc_i + 32'd4;
            valid_o    <= 1'b1;
        end else begin
            instr_o    <= NOP_INSTR;
            pc_o       <= 32'd0;
            pc_plus4_o <= 32'd0;
            valid_o    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Owns the fetch PC, issues one
// instruction-memory request at a time (req/gnt/rvalid), buffers a response
// that arrives while decode is stalled, and discards wrong-path responses
// after an execute-stage redirect.
//   clk, rst                : clock, synchronous active-high reset
//   StallF, StallD, FlushD  : hazard unit controls
//   PCSrcE, PCTargetE, ALUResultE : redirect select and targets
//   imem_req/addr/gnt/rvalid/rdata : instruction memory handshake
//   InstrD, PCD, PCPlus4D, ValidD  : IF/ID register outputs
//
// state | meaning
// IDLE  | nothing outstanding, may issue a request
// WAIT  | request outstanding, response is on the correct path
// DRAIN | request outstanding, response is wrong path and will be dropped
// HELD  | response buffered in hold_q while decode is stalled
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    import riscv_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  hold_q, hold_d;
    logic         redirect;
    logic [31:0]  target;
    logic         deliver;
    logic [31:0]  deliver_data;

    // Reserved encoding 11 behaves as sequential.
    assign redirect = (PCSrcE == PCSRC_BJAL) || (PCSrcE == PCSRC_JALR);
    assign target   = (PCSrcE == PCSRC_JALR) ? (ALUResultE & ~32'd1) : PCTargetE;

    assign imem_req  = (state_q == IDLE) && !StallF && !rst && !redirect;
    assign imem_addr = pcf_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        deliver      = 1'b0;
        deliver_data = hold_q;
        unique case (state_q)
            IDLE: begin
                if (imem_req && imem_gnt)
                    state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        state_d = IDLE;
                    end else if (StallD) begin
                        hold_d  = imem_rdata;
                        state_d = HELD;
                    end else begin
                        // A flushed delivery is dropped and the same PC refetched.
                        state_d      = IDLE;
                        deliver      = !FlushD;
                        deliver_data = imem_rdata;
                    end
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            HELD: begin
                if (redirect) begin
                    state_d = IDLE;
                end else if (!StallD) begin
                    state_d = IDLE;
                    deliver = !FlushD;
                end
            end
            DRAIN: begin
                if (imem_rvalid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pcf_d = pcf_q;
        if (redirect)
            pcf_d = target;
        else if (deliver)
            pcf_d = pcf_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pcf_q   <= RESET_PC;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            hold_q  <= hold_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (FlushD),
        .stall_i    (StallD),
        .load_i     (deliver),
        .instr_i    (deliver_data),
        .pc_i       (pcf_q),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        StallF, StallD, FlushD;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE, ALUResultE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .ALUResultE  (ALUResultE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 2'b00; PCTargetE = 32'd0; ALUResultE = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        step();
        step();
        chk("rst_req",     {31'd0, imem_req}, 32'd0);
        chk("rst_addr",    imem_addr, 32'h0);
        chk("rst_instr",   InstrD, 32'h0000_0013);
        chk("rst_pcd",     PCD, 32'h0);
        chk("rst_pcp4",    PCPlus4D, 32'h0);
        chk("rst_valid",   {31'd0, ValidD}, 32'd0);

        // Basic fetch: gnt in request cycle, rvalid next cycle.
        rst = 1'b0; imem_gnt = 1'b1; #1;
        chk("t1_req",      {31'd0, imem_req}, 32'd1);
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0; #1;
        chk("t1_instr",    InstrD, 32'h0050_0093);
        chk("t1_pcd",      PCD, 32'h0);
        chk("t1_pcp4",     PCPlus4D, 32'h4);
        chk("t1_valid",    {31'd0, ValidD}, 32'd1);
        chk("t1_addr",     imem_addr, 32'h4);

        // Response arrives during StallD, buffered for 3 cycles.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("t2_bubble",   {31'd0, ValidD}, 32'd0);
        StallD = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0; #1;
        chk("t2_req_held", {31'd0, imem_req}, 32'd0);
        chk("t2_hold1",    InstrD, 32'h0000_0013);
        step();
        chk("t2_hold2",    InstrD, 32'h0000_0013);
        step();
        chk("t2_hold3",    {31'd0, ValidD}, 32'd0);
        StallD = 1'b0;
        step();
        chk("t2_instr",    InstrD, 32'hDEAD_BEEF);
        chk("t2_pcd",      PCD, 32'h4);
        chk("t2_pcp4",     PCPlus4D, 32'h8);
        chk("t2_valid",    {31'd0, ValidD}, 32'd1);
        chk("t2_addr",     imem_addr, 32'h8);
        step();
        chk("t2_once",     {31'd0, ValidD}, 32'd0);

        // FlushD on a would-be deliver at PCF=8.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; FlushD = 1'b1;
        step();
        imem_rvalid = 1'b0; FlushD = 1'b0; #1;
        chk("t5_instr",    InstrD, 32'h0000_0013);
        chk("t5_valid",    {31'd0, ValidD}, 32'd0);
        chk("t5_addr",     imem_addr, 32'h8);
        chk("t5_req",      {31'd0, imem_req}, 32'd1);

        // Branch redirect while WAIT, response 2 cycles later is dropped.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h40;
        step();
        PCSrcE = 2'b00; #1;
        chk("t3_drain_req", {31'd0, imem_req}, 32'd0);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0; #1;
        chk("t3_valid",    {31'd0, ValidD}, 32'd0);
        chk("t3_instr",    InstrD, 32'h0000_0013);
        chk("t3_addr",     imem_addr, 32'h40);
        chk("t3_req",      {31'd0, imem_req}, 32'd1);

        // JALR redirect while IDLE, bit 0 cleared, no request that cycle.
        PCSrcE = 2'b10; ALUResultE = 32'h101; #1;
        chk("t4_noreq",    {31'd0, imem_req}, 32'd0);
        step();
        PCSrcE = 2'b00; #1;
        chk("t4_addr",     imem_addr, 32'h100);
        chk("t4_req",      {31'd0, imem_req}, 32'd1);

        // Reset while in DRAIN; stale rvalid afterwards is ignored.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h200;
        step();
        PCSrcE = 2'b00; #1;
        chk("t6_drain",    {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        step();
        chk("t6_req_rst",  {31'd0, imem_req}, 32'd0);
        chk("t6_addr",     imem_addr, 32'h0);
        chk("t6_instr",    InstrD, 32'h0000_0013);
        chk("t6_pcd",      PCD, 32'h0);
        chk("t6_pcp4",     PCPlus4D, 32'h0);
        chk("t6_valid",    {31'd0, ValidD}, 32'd0);
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
        step();
        imem_rvalid = 1'b0; #1;
        chk("t6_stale_valid", {31'd0, ValidD}, 32'd0);
        chk("t6_idle_req", {31'd0, imem_req}, 32'd1);
        chk("t6_idle_addr", imem_addr, 32'h0);

        // StallF gates the request.
        StallF = 1'b1; #1;
        chk("t7_stallf",   {31'd0, imem_req}, 32'd0);
        StallF = 1'b0;

        // PC wrap: fetch at FFFF_FFFC, next PC is 0.
        PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFFC;
        step();
        PCSrcE = 2'b00; #1;
        chk("t8_addr",     imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        step();
        imem_rvalid = 1'b0; #1;
        chk("t8_instr",    InstrD, 32'h00A0_0113);
        chk("t8_pcd",      PCD, 32'hFFFF_FFFC);
        chk("t8_pcp4",     PCPlus4D, 32'h0);
        chk("t8_wrap",     imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
